seq_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. It accepts instructions over a valid/ready handshake and sequences IDLE -> DECODE -> EXEC -> WB. It drives ALU and jump controls, waits on a multi-cycle ALU with a timeout, and flags illegal opcodes. It sits between the instruction fetch stage and the ALU / program-counter / register-file datapath.

---
 rtl/seq_cu_pkg.sv | 51 +++++
 rtl/seq_control_unit_if.sv | 33 +++
 rtl/seq_cu_timeout_cnt.sv | 31 +++
 rtl/seq_control_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_control_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_cu_pkg.sv
// seq_cu_pkg: shared FSM state encoding, opcode map and ALU operation encodings
// for the multi-cycle sequencing control unit.
package seq_cu_pkg;

  // Sequencer states; the top keeps them as plain 2-bit constants.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  // Opcode map (low three bits of the opcode field).
  localparam logic [2:0] OPC_ADD  = 3'd0;
  localparam logic [2:0] OPC_SUB  = 3'd1;
  localparam logic [2:0] OPC_AND  = 3'd2;
  localparam logic [2:0] OPC_OR   = 3'd3;
  localparam logic [2:0] OPC_JUMP = 3'd4;
  localparam logic [2:0] OPC_JZ   = 3'd5;
  localparam logic [2:0] OPC_NOP  = 3'd6;

  // ALU operation select encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Low opcode bits name a defined instruction (7 is the only hole).
  function automatic logic opc_is_legal(input logic [2:0] opc);
    return (opc <= OPC_NOP);
  endfunction

  // ALU instructions occupy opcodes 0..3.
  function automatic logic opc_is_alu(input logic [2:0] opc);
    return (opc[2] == 1'b0);
  endfunction

  // Map an ALU opcode to its operation select.
  function automatic logic [1:0] opc_alu_sel(input logic [2:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_ADD: sel = ALU_ADD;
      OPC_SUB: sel = ALU_SUB;
      OPC_AND: sel = ALU_AND;
      OPC_OR:  sel = ALU_OR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// seq_control_unit_if: instruction handshake plus ALU / PC / register-file
// control bundle. The control unit uses the slave view; the fetch/datapath
// side (or a testbench) uses the master view.
interface seq_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int OP_W     = 2
) ();

  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                zero_flag;
  logic                alu_done;
  logic                alu_op;
  logic [OP_W-1:0]     op;
  logic                jmp_op;
  logic                pc_inc;
  logic                reg_we;
  logic                illegal;
  logic                timeout;
  logic                busy;

  modport slave (
    input  instr_valid, opcode, zero_flag, alu_done,
    output instr_ready, alu_op, op, jmp_op, pc_inc, reg_we, illegal, timeout, busy
  );

  modport master (
    output instr_valid, opcode, zero_flag, alu_done,
    input  instr_ready, alu_op, op, jmp_op, pc_inc, reg_we, illegal, timeout, busy
  );

endinterface

// File: rtl/seq_cu_timeout_cnt.sv
// seq_cu_timeout_cnt: down-counter bounding how long EXEC waits on the ALU.
// load presets LIMIT-1, dec counts toward zero, expired flags a zero count.
module seq_cu_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // Count register: clear has priority over load, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(LIMIT - 1);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle instruction sequencer IDLE -> DECODE -> EXEC -> WB.
// Drives ALU, jump and write-back controls, bounds ALU waits with a timeout and
// flags illegal opcodes. All outputs are registered.
// Optional: define SEQ_CU_PERF_CNT_EN to add retired_cnt / illegal_cnt ports.
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int OP_W        = 2,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SEQ_CU_PERF_CNT_EN
  output logic [31:0]         retired_cnt,
  output logic [15:0]         illegal_cnt,
`endif
  seq_control_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_DECODE = 2'(DECODE);
  localparam logic [1:0] S_EXEC   = 2'(EXEC);
  localparam logic [1:0] S_WB     = 2'(WB);

  logic [1:0]          state_reg, state_next;
  logic [OPCODE_W-1:0] opcode_reg, opcode_next;
  logic                instr_ready_reg, instr_ready_next;
  logic                busy_reg, busy_next;
  logic                alu_op_reg, alu_op_next;
  logic [OP_W-1:0]     op_reg, op_next;
  logic                jmp_op_reg, jmp_op_next;
  logic                pc_inc_reg, pc_inc_next;
  logic                reg_we_reg, reg_we_next;
  logic                illegal_reg, illegal_next;
  logic                timeout_reg, timeout_next;

  logic                cnt_load, cnt_clear, cnt_dec, cnt_expired;

  logic [2:0]          opc_low;
  logic                upper_set;
  logic                opc_illegal;
  logic                opc_alu;
  logic                handshake;

  assign opc_low = opcode_reg[2:0];

  // Any set bit above the 3-bit opcode field makes the instruction illegal.
  generate
    if (OPCODE_W > 3) begin : g_wide_opc
      assign upper_set = |opcode_reg[OPCODE_W-1:3];
    end else begin : g_narrow_opc
      assign upper_set = 1'b0;
    end
  endgenerate

  assign opc_illegal = upper_set || !opc_is_legal(opc_low);
  assign opc_alu     = !opc_illegal && opc_is_alu(opc_low);
  assign handshake   = bus.instr_valid && instr_ready_reg;

  seq_cu_timeout_cnt #(
    .LIMIT (ALU_TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .clear   (cnt_clear),
    .dec     (cnt_dec),
    .expired (cnt_expired)
  );

  // Next-state and next-output logic; pulses default low, levels hold.
  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    alu_op_next  = alu_op_reg;
    op_next      = op_reg;
    jmp_op_next  = 1'b0;
    pc_inc_next  = 1'b0;
    reg_we_next  = 1'b0;
    illegal_next = 1'b0;
    timeout_next = 1'b0;
    cnt_load     = 1'b0;
    cnt_clear    = 1'b0;
    cnt_dec      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          opcode_next = bus.opcode;
          state_next  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (opc_illegal) begin
          illegal_next = 1'b1;
          pc_inc_next  = 1'b1;
          state_next   = S_IDLE;
        end else if (opc_alu) begin
          alu_op_next = 1'b1;
          op_next     = OP_W'(opc_alu_sel(opc_low));
          cnt_load    = 1'b1;
          state_next  = S_EXEC;
        end else if ((opc_low == OPC_JUMP) || (opc_low == OPC_JZ)) begin
          state_next = S_EXEC;
        end else begin
          // NOP retires straight away.
          pc_inc_next = 1'b1;
          state_next  = S_IDLE;
        end
      end

      S_EXEC: begin
        if (opc_alu) begin
          // alu_done is checked first so it wins over a same-cycle expiry.
          if (bus.alu_done) begin
            alu_op_next = 1'b0;
            cnt_clear   = 1'b1;
            reg_we_next = 1'b1;
            pc_inc_next = 1'b1;
            state_next  = S_WB;
          end else if (cnt_expired) begin
            alu_op_next  = 1'b0;
            cnt_clear    = 1'b1;
            timeout_next = 1'b1;
            pc_inc_next  = 1'b1;
            state_next   = S_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end else begin
          if ((opc_low == OPC_JZ) && !bus.zero_flag) begin
            pc_inc_next = 1'b1;
          end else begin
            jmp_op_next = 1'b1;
          end
          state_next = S_IDLE;
        end
      end

      S_WB: begin
        // reg_we / pc_inc were raised on entry; they drop as we leave.
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    instr_ready_next = (state_next == S_IDLE);
    busy_next        = (state_next != S_IDLE);
  end

  // State and registered outputs; reset clears everything including instr_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      opcode_reg      <= '0;
      instr_ready_reg <= 1'b0;
      busy_reg        <= 1'b0;
      alu_op_reg      <= 1'b0;
      op_reg          <= '0;
      jmp_op_reg      <= 1'b0;
      pc_inc_reg      <= 1'b0;
      reg_we_reg      <= 1'b0;
      illegal_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      opcode_reg      <= opcode_next;
      instr_ready_reg <= instr_ready_next;
      busy_reg        <= busy_next;
      alu_op_reg      <= alu_op_next;
      op_reg          <= op_next;
      jmp_op_reg      <= jmp_op_next;
      pc_inc_reg      <= pc_inc_next;
      reg_we_reg      <= reg_we_next;
      illegal_reg     <= illegal_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign bus.instr_ready = instr_ready_reg;
  assign bus.busy        = busy_reg;
  assign bus.alu_op      = alu_op_reg;
  assign bus.op          = op_reg;
  assign bus.jmp_op      = jmp_op_reg;
  assign bus.pc_inc      = pc_inc_reg;
  assign bus.reg_we      = reg_we_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.timeout     = timeout_reg;

`ifdef SEQ_CU_PERF_CNT_EN
  logic [31:0] retired_cnt_reg;
  logic [15:0] illegal_cnt_reg;
  logic        retire_evt;

  // A retirement is a write-back, a taken jump or a NOP's PC increment.
  assign retire_evt = reg_we_next || jmp_op_next ||
                      ((state_reg == S_DECODE) && pc_inc_next && !illegal_next);

  // Free-running wrapping event counters, updated with the pulse they count.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_reg <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      if (retire_evt) begin
        retired_cnt_reg <= retired_cnt_reg + 32'd1;
      end
      if (illegal_next) begin
        illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
      end
    end
  end

  assign retired_cnt = retired_cnt_reg;
  assign illegal_cnt = illegal_cnt_reg;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: table-driven transaction bench with an expected-result
// queue, plus hand-written reset and mid-EXEC abort sequences.
module tb_seq_control_unit;

  localparam int OPCODE_W    = 3;
  localparam int OP_W        = 2;
  localparam int ALU_TIMEOUT = 4;
  localparam int NVEC        = 14;
  localparam int ABORT_AT    = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_control_unit_if #(.OPCODE_W(OPCODE_W), .OP_W(OP_W)) bus ();

`ifdef SEQ_CU_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [15:0] illegal_cnt;
  int          exp_retired = 0;
  int          exp_illegal = 0;
`endif

  seq_control_unit #(
    .OPCODE_W    (OPCODE_W),
    .OP_W        (OP_W),
    .ALU_TIMEOUT (ALU_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_CU_PERF_CNT_EN
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt),
`endif
    .bus         (bus)
  );

  typedef struct {
    int opc;      // opcode driven
    int zf;       // zero_flag driven
    int done_at;  // EXEC cycle (1-based) that sees alu_done=1; 0 = never
    int we;       // expected reg_we pulses
    int pc;       // expected pc_inc pulses
    int jmp;      // expected jmp_op pulses
    int ill;      // expected illegal pulses
    int to;       // expected timeout pulses
    int alu;      // expected cycles with alu_op=1
    int op;       // expected op while alu_op=1
    int op_end;   // expected op when ready returns
    int lat;      // cycle after handshake where instr_ready returns
  } vec_t;

  vec_t vecs[NVEC];
  vec_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input int opc, zf, done_at, we, pc, jmp, ill, to, alu, op, op_end, lat);
    vec_t v;
    v.opc = opc; v.zf = zf; v.done_at = done_at;
    v.we = we; v.pc = pc; v.jmp = jmp; v.ill = ill; v.to = to;
    v.alu = alu; v.op = op; v.op_end = op_end; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.instr_ready, bus.alu_op, bus.op, bus.jmp_op, bus.pc_inc,
                bus.reg_we, bus.illegal, bus.timeout, bus.busy});
  endfunction

  function automatic logic [31:0] quiet_outs();
    return 32'({bus.alu_op, bus.jmp_op, bus.pc_inc, bus.reg_we,
                bus.illegal, bus.timeout, bus.busy});
  endfunction

  // One instruction: handshake, react as the ALU, tally outputs until ready returns.
  task automatic run_txn(input vec_t v, input int idx);
    vec_t e;
    int   waitc, cyc, lat, alu_cyc, n_we, n_pc, n_jmp, n_ill, n_to, op_bad, viol;
    logic [OP_W-1:0] op_seen;
    waitc = 0;
    while (bus.instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check($sformatf("t%0d_ready_wait", idx), 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.opcode      = OPCODE_W'(v.opc);
    bus.zero_flag   = (v.zf != 0);
    bus.alu_done    = 1'b0;
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    cyc = 1; lat = 0; alu_cyc = 0; n_we = 0; n_pc = 0; n_jmp = 0; n_ill = 0; n_to = 0;
    op_bad = 0; viol = 0; op_seen = '0;
    while (lat == 0 && cyc <= 40) begin
      if (bus.alu_op === 1'b1) begin
        alu_cyc++;
        if (alu_cyc == 1) op_seen = bus.op;
        else if (bus.op !== op_seen) op_bad++;
      end
      if (bus.reg_we === 1'b1)  n_we++;
      if (bus.pc_inc === 1'b1)  n_pc++;
      if (bus.jmp_op === 1'b1)  n_jmp++;
      if (bus.illegal === 1'b1) n_ill++;
      if (bus.timeout === 1'b1) n_to++;
      if (bus.jmp_op === 1'b1 && bus.pc_inc === 1'b1) viol++;
      if (bus.busy !== ~bus.instr_ready) viol++;
      if (bus.instr_ready === 1'b1) begin
        lat = cyc;
      end else begin
        bus.alu_done = (bus.alu_op === 1'b1) && (v.done_at != 0) && (alu_cyc == v.done_at);
        @(negedge clk);
        cyc++;
      end
    end
    bus.alu_done = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("t%0d_latency", idx), 32'(lat), 32'(e.lat));
    check($sformatf("t%0d_reg_we", idx), 32'(n_we), 32'(e.we));
    check($sformatf("t%0d_pc_inc", idx), 32'(n_pc), 32'(e.pc));
    check($sformatf("t%0d_jmp_op", idx), 32'(n_jmp), 32'(e.jmp));
    check($sformatf("t%0d_illegal", idx), 32'(n_ill), 32'(e.ill));
    check($sformatf("t%0d_timeout", idx), 32'(n_to), 32'(e.to));
    check($sformatf("t%0d_alu_cycles", idx), 32'(alu_cyc), 32'(e.alu));
    if (e.alu > 0) begin
      check($sformatf("t%0d_op", idx), 32'(op_seen), 32'(e.op));
      check($sformatf("t%0d_op_stable", idx), 32'(op_bad), 32'd0);
    end
    check($sformatf("t%0d_op_hold", idx), 32'(bus.op), 32'(e.op_end));
    check($sformatf("t%0d_busy_excl", idx), 32'(viol), 32'd0);
`ifdef SEQ_CU_PERF_CNT_EN
    exp_retired += e.we + e.jmp + ((e.opc == 6) ? 1 : 0);
    exp_illegal += e.ill;
`endif
    $display("txn %0d opc=%0d zf=%0d done_at=%0d lat=%0d alu=%0d we=%0d pc=%0d jmp=%0d ill=%0d to=%0d op=%0d",
             idx, v.opc, v.zf, v.done_at, lat, alu_cyc, n_we, n_pc, n_jmp, n_ill, n_to, bus.op);
  endtask

  // Hard stop so a hung DUT cannot stall the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                opc zf done we pc jmp ill to alu op end lat
    vecs[0]  = mk(0, 0, 3, 1, 1, 0, 0, 0, 3, 0, 0, 6);   // ADD, done on 3rd EXEC cycle
    vecs[1]  = mk(1, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 4);   // SUB, immediate done
    vecs[2]  = mk(2, 0, 2, 1, 1, 0, 0, 0, 2, 2, 2, 5);   // AND
    vecs[3]  = mk(3, 0, 4, 1, 1, 0, 0, 0, 4, 3, 3, 7);   // OR, done collides with expiry
    vecs[4]  = mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 3);   // JUMP, op holds 3
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 4, 1, 1, 6);   // SUB, ALU never done
    vecs[6]  = mk(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3);   // JZ taken
    vecs[7]  = mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3);   // JZ not taken
    vecs[8]  = mk(6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2);   // NOP
    vecs[9]  = mk(7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 2);   // illegal
    vecs[10] = mk(2, 0, 1, 1, 1, 0, 0, 0, 1, 2, 2, 4);   // AND after abort (op was reset)
    vecs[11] = mk(7, 1, 0, 0, 1, 0, 1, 0, 0, 0, 2, 2);   // illegal back-to-back
    vecs[12] = mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 3);   // JZ not taken
    vecs[13] = mk(6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2);   // NOP

    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = '0;
    bus.zero_flag   = 1'b0;
    bus.alu_done    = 1'b0;

    // Reset held with a pending instruction: nothing accepted, all outputs low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outs_c%0d", i), all_outs(), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(bus.instr_ready), 32'd1);
    check("post_reset_no_accept", 32'(bus.busy), 32'd0);
    bus.instr_valid = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (i == ABORT_AT) begin
        // OR aborted by reset in its second EXEC cycle.
        bus.instr_valid = 1'b1;
        bus.opcode      = OPCODE_W'(3);
        bus.alu_done    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", 32'(bus.alu_op), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", all_outs(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_release_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_no_pulse", quiet_outs(), 32'd0);
`ifdef SEQ_CU_PERF_CNT_EN
        check("abort_retired_cnt", retired_cnt, 32'd0);
        check("abort_illegal_cnt", 32'(illegal_cnt), 32'd0);
        exp_retired = 0;
        exp_illegal = 0;
`endif
        $display("txn abort opc=3 reset during EXEC");
      end
      run_txn(vecs[i], i);
    end

`ifdef SEQ_CU_PERF_CNT_EN
    check("retired_cnt", retired_cnt, 32'(exp_retired));
    check("illegal_cnt", 32'(illegal_cnt), 32'(exp_illegal));
`endif
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
